// File: rtl/apb_cmd_master_pkg.sv
// Shared types and constants for the valid/ready-to-APB4 command master.
package apb_cmd_master_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;
    localparam int unsigned APB_STRB_WIDTH = APB_DATA_WIDTH / 8;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0BAD_0A0B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] paddr;
        logic [2:0]                pprot;
        logic                      psel;
        logic                      penable;
        logic                      pwrite;
        logic [APB_DATA_WIDTH-1:0] pwdata;
        logic [APB_STRB_WIDTH-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic                      pready;
        logic [APB_DATA_WIDTH-1:0] prdata;
        logic                      pslverr;
    } apb_resp_t;

    typedef struct packed {
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [APB_DATA_WIDTH-1:0] wdata;
        logic [APB_STRB_WIDTH-1:0] strb;
    } cmd_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
    } rsp_t;

    // Selected request for a latched command; reads never carry data or strobes.
    function automatic apb_req_t cmd_to_req(cmd_t cmd, logic enable);
        apb_req_t req;
        req         = '0;
        req.paddr   = cmd.addr;
        req.pprot   = 3'b000;
        req.psel    = 1'b1;
        req.penable = enable;
        req.pwrite  = cmd.write;
        req.pwdata  = cmd.write ? cmd.wdata : '0;
        req.pstrb   = cmd.write ? cmd.strb : '0;
        return req;
    endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 master driven by a valid/ready command stream.
// Define APB_CMD_MASTER_TIMEOUT_EN to abort ACCESS after TimeoutCycles stalls.
module apb_cmd_master
    import apb_cmd_master_pkg::*;
#(
    parameter int unsigned  ApbAddrWidth  = APB_ADDR_WIDTH,
    parameter int unsigned  ApbDataWidth  = APB_DATA_WIDTH,
    parameter int unsigned  TimeoutCycles = 16,
    parameter type          req_t         = apb_req_t,
    parameter type          resp_t        = apb_resp_t,
    localparam int unsigned StrbWidth     = ApbDataWidth / 8
) (
    input  logic                    pclk_i,
    input  logic                    preset_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ApbAddrWidth-1:0] cmd_addr_i,
    input  logic                    cmd_write_i,
    input  logic [ApbDataWidth-1:0] cmd_wdata_i,
    input  logic [StrbWidth-1:0]    cmd_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [ApbDataWidth-1:0] rsp_rdata_o,
    output logic                    rsp_err_o,
    output req_t                    apb_req_o,
    input  resp_t                   apb_resp_i
);

    state_e state_q, state_d;
    cmd_t   cmd_q, cmd_d, cmd_in;
    rsp_t   rsp_q, rsp_d;
    req_t   req_d;
    logic   timeout;

    assign cmd_in = '{addr: cmd_addr_i, write: cmd_write_i, wdata: cmd_wdata_i, strb: cmd_strb_i};

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

    logic [CntWidth-1:0] tmo_cnt_q;

    // Counts ACCESS cycles that ended without pready.
    always_ff @(posedge pclk_i) begin
        if (!preset_ni) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ACCESS && !apb_resp_i.pready && !timeout) begin
            tmo_cnt_q <= tmo_cnt_q + CntWidth'(1);
        end
    end

    assign timeout = (tmo_cnt_q == CntWidth'(TimeoutCycles));
`else
    // ACCESS waits for pready indefinitely; TimeoutCycles has no effect here.
    assign timeout = 1'b0 && (TimeoutCycles == 0);
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rsp_d   = rsp_q;
        req_d   = apb_req_o;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    cmd_d   = cmd_in;
                    req_d   = cmd_to_req(cmd_in, 1'b0);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = cmd_to_req(cmd_q, 1'b1);
                state_d = ACCESS;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (apb_resp_i.pready) begin
                    rsp_d.rdata = cmd_q.write ? '0 : apb_resp_i.prdata;
                    rsp_d.err   = apb_resp_i.pslverr;
                    req_d       = '0;
                    state_d     = RESP;
                end else if (timeout) begin
                    rsp_d.rdata = ApbDataWidth'(TIMEOUT_RDATA);
                    rsp_d.err   = 1'b1;
                    req_d       = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_o && rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (!preset_ni) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            apb_req_o   <= '0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            apb_req_o   <= req_d;
            cmd_ready_o <= (state_d == IDLE);
            rsp_valid_o <= (state_d == RESP);
        end
    end

    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master with a small register-slave model attached.
module tb_apb_cmd_master;
    import apb_cmd_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    apb_req_t    apb_req;
    apb_resp_t   apb_resp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apb_cmd_master dut (
        .pclk_i      (clk),
        .preset_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_write_i (cmd_write),
        .cmd_wdata_i (cmd_wdata),
        .cmd_strb_i  (cmd_strb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .apb_req_o   (apb_req),
        .apb_resp_i  (apb_resp)
    );

    // Register block rules: base 0x1000, four words, word 3 read-only.
    function automatic logic mapped(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h1010);
    endfunction

    function automatic logic reg_err(input logic [31:0] a, input logic wr);
        return !mapped(a) || (wr && a[3:2] == 2'd3);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] v;
        v = old;
        for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
        return v;
    endfunction

    // Slave: random or forced wait states; drives a stray response outside ACCESS.
    logic [31:0] slv_regs [4] = '{default: 32'h0000_0011};
    int          slv_wait = 0;
    int          slv_last_wait = 0;
    int          max_wait = 0;
    int          force_wait = -1;

    always_comb begin
        apb_resp = '{pready: 1'b1, prdata: 32'hDEAD_BEEF, pslverr: 1'b1};
        if (apb_req.psel && apb_req.penable) begin
            apb_resp.pready  = (slv_wait == 0);
            apb_resp.pslverr = reg_err(apb_req.paddr, apb_req.pwrite);
            if (apb_req.pwrite)           apb_resp.prdata = 32'h5A5A_5A5A;
            else if (mapped(apb_req.paddr)) apb_resp.prdata = slv_regs[apb_req.paddr[3:2]];
            else                           apb_resp.prdata = 32'h0BAD_B10C;
        end
    end

    always @(posedge clk) begin : slave_seq
        int w;
        if (apb_req.psel && !apb_req.penable) begin
            w = (force_wait >= 0) ? force_wait : int'($urandom_range(max_wait, 0));
            slv_wait      <= w;
            slv_last_wait <= w;
        end else if (apb_req.psel && apb_req.penable) begin
            if (slv_wait == 0) begin
                if (apb_req.pwrite && !reg_err(apb_req.paddr, 1'b1))
                    slv_regs[apb_req.paddr[3:2]] <= merge(slv_regs[apb_req.paddr[3:2]],
                                                          apb_req.pwdata, apb_req.pstrb);
            end else begin
                slv_wait <= slv_wait - 1;
            end
        end
    end

    // Reference model of the whole transaction outcome.
    logic [31:0] ref_regs [4] = '{default: 32'h0000_0011};

    task automatic model(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, output logic [31:0] rd, output logic err);
        err = reg_err(a, wr);
        rd  = 32'h0;
        if (!wr)       rd = mapped(a) ? ref_regs[a[3:2]] : 32'h0BAD_B10C;
        else if (!err) ref_regs[a[3:2]] = merge(ref_regs[a[3:2]], wd, st);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command through to its response handshake; exp_lat < 0 means 3 + slave waits.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int stall);
        apb_req_t exp_req;
        apb_req_t zero_req;
        int       n;
        int       lat;
        zero_req  = '0;
        cmd_addr  = a;
        cmd_write = wr;
        cmd_wdata = wd;
        cmd_strb  = st;
        cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_bound", 128'(n < 100), 128'(1));
        if (n >= 100) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        // Garbage on the command inputs must not leak into the latched transfer.
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom_range(1, 0));
        cmd_strb  = 4'($urandom_range(15, 0));
        exp_req         = '0;
        exp_req.paddr   = a;
        exp_req.psel    = 1'b1;
        exp_req.pwrite  = wr;
        exp_req.pwdata  = wr ? wd : 32'h0;
        exp_req.pstrb   = wr ? st : 4'h0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            exp_req.penable = (lat > 1);
            chk("req_phase", 128'({cmd_ready, apb_req}), 128'({1'b0, exp_req}));
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        chk("rsp_valid_bound", 128'(rsp_valid), 128'(1));
        chk("latency", 128'(lat), 128'((exp_lat >= 0) ? exp_lat : 3 + slv_last_wait));
        chk("rsp_data", 128'({rsp_rdata, rsp_err, cmd_ready, apb_req}),
            128'({exp_rd, exp_err, 1'b0, zero_req}));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("rsp_stall", 128'({rsp_valid, rsp_rdata, rsp_err, cmd_ready, apb_req.psel}),
                128'({1'b1, exp_rd, exp_err, 1'b0, 1'b0}));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_handshake", 128'({rsp_valid, cmd_ready, apb_req.psel}), 128'(3'b010));
    endtask

    task automatic run_exp(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                           input int stall);
        logic [31:0] rd;
        logic        err;
        model(a, wr, wd, st, rd, err);
        xfer(a, wr, wd, st, exp_rd, exp_err, -1, stall);
    endtask

    task automatic run_rand(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, input int stall);
        logic [31:0] rd;
        logic        err;
        model(a, wr, wd, st, rd, err);
        xfer(a, wr, wd, st, rd, err, -1, stall);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, apb_req}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 128'({cmd_ready, rsp_valid, apb_req.psel}), 128'(3'b100));

        run_exp(32'h1004, 1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 0);
        run_exp(32'h1004, 1'b0, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b0, 0);
        run_exp(32'h1008, 1'b1, 32'hFFFF_FFFF, 4'h2, 32'h0, 1'b0, 0);
        run_exp(32'h1008, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0000_FF11, 1'b0, 0);
        run_exp(32'h100C, 1'b1, 32'h1234_5678, 4'hF, 32'h0, 1'b1, 0);
        run_exp(32'h1010, 1'b0, 32'h0,         4'h0, 32'h0BAD_B10C, 1'b1, 0);
        run_exp(32'h100C, 1'b0, 32'h0,         4'h0, 32'h0000_0011, 1'b0, 0);
        run_exp(32'h1000, 1'b1, 32'h0000_00FF, 4'h0, 32'h0, 1'b0, 0);
        run_exp(32'h1000, 1'b0, 32'h0,         4'h0, 32'h0000_0011, 1'b0, 5);

        // Reset while the slave holds ACCESS; the write must never complete.
        force_wait = 1000;
        cmd_addr = 32'h1000; cmd_write = 1'b1; cmd_wdata = 32'hCAFE_F00D; cmd_strb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("in_access", 128'({apb_req.psel, apb_req.penable}), 128'(2'b11));
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_access", 128'({apb_req.psel, rsp_valid, cmd_ready}), 128'(3'b000));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_idle", 128'({apb_req.psel, rsp_valid, cmd_ready}), 128'(3'b001));
        end
        force_wait = -1;
        run_exp(32'h1000, 1'b0, 32'h0, 4'h0, 32'h0000_0011, 1'b0, 0);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
        force_wait = 1000;
        xfer(32'h1004, 1'b0, 32'h0, 4'h0, 32'h0BAD_0A0B, 1'b1, 19, 0);
`else
        force_wait = 30;
        run_exp(32'h1004, 1'b0, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 0);
`endif
        force_wait = -1;

        max_wait = 3;
        for (int t = 0; t < 60; t++) begin
            run_rand(32'h1000 + 32'(4 * $urandom_range(5, 0)), 1'($urandom_range(1, 0)),
                     $urandom, 4'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Single-outstanding APB4 master. Converts a valid/ready command stream (addr, write, wdata, strb) into one APB4 transfer at a time.
- Returns read data and error on a valid/ready response stream.
- Sits directly upstream of the APB register slaves (apb_regs and siblings), driving their req_t and consuming their resp_t.
- Used by boot sequencers and debug bridges that have no native APB master.

Parameters:
- ApbAddrWidth, 32, width of paddr and cmd_addr_i.
- ApbDataWidth, 32, width of pwdata/prdata; range 8..32.
- TimeoutCycles, 16, max ACCESS cycles before abort (only used with the optional feature); must be >= 1.
- req_t, logic, APB4 request struct (paddr, pprot, psel, penable, pwrite, pwdata, pstrb).
- resp_t, logic, APB4 response struct (pready, prdata, pslverr).
- Derived, do not override: StrbWidth = ApbDataWidth/8.

Ports:
- pclk_i  in  1  clock.
- preset_ni  in  1  reset, synchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when valid & ready.
- cmd_addr_i  in  ApbAddrWidth  target address.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_wdata_i  in  ApbDataWidth  write data.
- cmd_strb_i  in  StrbWidth  byte strobes (writes only).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid & ready.
- rsp_rdata_o  out  ApbDataWidth  read data; 0 for writes.
- rsp_err_o  out  1  pslverr or timeout.
- apb_req_o  out  req_t  APB4 request to slave.
- apb_resp_i  in  resp_t  APB4 response from slave.

Behaviour:
- Reset is synchronous, active-low; all state is sampled only on the pclk_i edge.
- Reset values: state IDLE; cmd_ready_o=0 during reset, then 1 in IDLE; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; apb_req_o all zero.
- FSM states and transitions:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr/write/wdata/strb and go to SETUP. cmd_ready_o=0 in every other state.
  - SETUP: psel=1, penable=0, request fields from the latch. Unconditionally go to ACCESS next cycle.
  - ACCESS: psel=1, penable=1, fields held stable.
    - On pready=1: capture prdata (reads only; writes capture 0) and pslverr; go to RESP.
    - On pready=0: stay.
  - RESP: psel=0, penable=0, rsp_valid_o=1, data/err held stable. On rsp_ready_i, go to IDLE.
- Request field rules:
  - pprot is always 3'b000.
  - For reads, pwdata=0 and pstrb=0 (APB4 rule). For writes, pstrb = latched strb; a zero strobe is still issued as a transfer.
  - When psel=0, all request fields are driven to 0.
- Latency with a zero-wait slave: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3. Maximum throughput is one transfer per 4 cycles with rsp_ready_i held high.
- Boundary conditions:
  - cmd_valid_i is ignored outside IDLE; the command source must hold it.
  - A new command is never accepted in the same cycle as a response handshake.
  - rsp_ready_i held low stalls in RESP indefinitely with outputs stable.
  - Reset asserted mid-ACCESS forces IDLE next edge. psel drops immediately at that edge and no response is produced.
  - apb_resp_i is ignored outside ACCESS, so stray pready/pslverr has no effect.

Optional Feature:
- Macro: APB_CMD_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TimeoutCycles+1) clears in SETUP and increments each ACCESS cycle with pready=0.
  - When it reaches TimeoutCycles, the transfer aborts: next state RESP, psel drops, rsp_err_o=1, rsp_rdata_o=32'h0BAD_0A0B truncated to ApbDataWidth.
  - pready arriving in the same cycle as the timeout wins and is a normal completion.
- Without the macro: no counter is built and ACCESS waits forever.

Decomposition:
- Package apb_cmd_master_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP; 2 bits);
  - localparam TIMEOUT_RDATA = 32'h0BAD_0A0B;
  - command/response struct typedefs, built from the existing APB typedef macros.
- No sub-module; a single FSM plus data latches. An interface wrapper apb_cmd_master_intf (APB.Master) is natural, mirroring existing _intf wrappers.

Test Plan (bench attaches apb_regs: base 0x1000, 4 regs, ReadOnly=4'b1000, reg_init all 0x0000_0011):
- Write 0x1004 data 0xA5A5_A5A5 strb 0xF, then read 0x1004 -> write rsp_err=0, rdata=0. Read rdata=0xA5A5_A5A5, rsp_valid exactly 3 cycles after each accept.
- Write 0x1008 data 0xFFFF_FFFF strb 0x2, then read 0x1008 -> rdata=0x0000_FF11, err=0. Read-cycle pstrb=0, pwdata=0.
- Write 0x100C (read-only) and read 0x1010 (unmapped) -> both rsp_err=1. Read rdata=0x0BAD_B10C. Then read 0x100C -> 0x0000_0011, err=0.
- Hold rsp_ready_i=0 for 5 cycles after rsp_valid -> rsp fields stable, cmd_ready_o=0, psel=0 throughout. Accept resumes the cycle after the handshake.
- Assert preset_ni=0 for one edge while in ACCESS -> next cycle psel=0, rsp_valid_o=0, cmd_ready_o=1 after release, no response emitted.
- (TIMEOUT_EN, TimeoutCycles=16, stub slave with pready=0) -> rsp_valid at accept+2+16+1, rsp_err=1, rdata=0x0BAD_0A0B.
